nts_tx_arbiter: RTL
===================

Name: nts_tx_arbiter

Overview:
Multi-engine TX collector between the ENGINES NTS engines and the MAC TX path. It replaces the single-engine dummy TX drain. The block round-robin selects an engine with a finished response packet, drains that engine's TX FIFO word by word, and presents the words as a MAC stream with ready backpressure. On the last word it converts the engine's left-aligned partial word into the MAC's right-aligned byte-mask format.

Parameters:
ENGINES, 4, number of engine TX ports (1..16)
MAC_DATA_WIDTH, 64, MAC word width in bits; must be a multiple of 8
BYTES, MAC_DATA_WIDTH/8, derived; bytes per word
BLW_WIDTH, 4, width of each engine's bytes_last_word field

Ports:
i_clk  in  1  clock
i_areset  in  1  reset, synchronous, active-high
i_engine_tx_packet_available  in  ENGINES  engine has a complete TX packet
o_engine_tx_packet_read  out  ENGINES  one-cycle pulse: packet consumed
i_engine_tx_fifo_empty  in  ENGINES  engine TX FIFO empty
o_engine_tx_fifo_rd_en  out  ENGINES  one-cycle read strobe
i_engine_tx_fifo_rd_data  in  MAC_DATA_WIDTH*ENGINES  packed read data, valid the cycle after rd_en
i_engine_tx_bytes_last_word  in  BLW_WIDTH*ENGINES  valid byte count of last word; 0 means BYTES
o_mac_tx_valid  out  1  word presented
i_mac_tx_ready  in  1  MAC accepts word when valid&ready
o_mac_tx_data  out  MAC_DATA_WIDTH  word data
o_mac_tx_data_valid  out  BYTES  byte mask, right-aligned (LSBs)
o_mac_tx_last  out  1  final word of packet
o_busy  out  1  state != IDLE
o_packets_sent  out  32  wrapping count of packets whose last word was accepted
o_empty_packets  out  32  wrapping count of packets released with zero words

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = ENGINES-1, so engine 0 has first priority.
- Reset mid-packet: same as above; no packet_read pulse is issued and the word in flight is dropped.
- IDLE: search (last_grant+1 .. last_grant+ENGINES) mod ENGINES for available=1. First hit becomes grant; go to FETCH.
- FETCH:
  - If empty[grant]=1: increment o_empty_packets and go to RELEASE.
  - Otherwise pulse rd_en[grant] and go to WAIT.
- WAIT: capture rd_data[grant] into the hold register; go to HOLD.
- HOLD:
  - o_mac_tx_valid=1; last = empty[grant] sampled in HOLD.
  - Not-last word: data_valid = all ones; data = hold register.
  - Last word: n = bytes_last_word[grant] (0 maps to BYTES). data = hold >> 8*(BYTES-n). data_valid = (1<<n)-1. Bytes above n are 0. Values n>BYTES are treated as BYTES.
  - Outputs stay stable while valid & !ready.
  - On accept with last=0: pulse rd_en[grant] and go to WAIT.
  - On accept with last=1: increment o_packets_sent and go to RELEASE.
- RELEASE: pulse packet_read[grant] for one cycle; last_grant <= grant; go to GUARD.
- GUARD: one idle cycle, so the engine can deassert available; then go to IDLE.
- Throughput: 1 word per 2 cycles while ready=1.
- Only the granted engine ever sees rd_en or packet_read. At most one bit of each vector is high.
- Simultaneous availability is resolved by round-robin. An engine that raises available while another is being drained waits its turn.
- Counters wrap at 2^32.

Decomposition:
- Package nts_tx_pkg: state encoding (IDLE, FETCH, WAIT, HOLD, RELEASE, GUARD) and the right-align/mask helper function.
- Sub-module nts_rr_arbiter: parametrised ENGINES round-robin picker. Inputs: request vector and last_grant. Outputs: grant index and hit flag. Purely combinational, reusable for a later RX multi-engine dispatcher.

Test Plan:
- Engine 0 holds a 3-word packet (0x1111..., 0x2222..., 0xAABBCC0000000000), bytes_last_word=3, ready=1 → three words out. Last word data=0x0000000000AABBCC, data_valid=8'b0000_0111, last=1. Exactly one packet_read[0] pulse; o_packets_sent=1.
- Engines 1 and 3 are both available at reset → grant order 1 then 3. Next, 0 and 1 become available → grant order is 0, then 1 (search starts after last_grant=3).
- ready held low for 5 cycles in HOLD → data, data_valid and last remain stable; no extra rd_en is issued.
- available=1 with empty=1 → no MAC valid; packet_read pulse; o_empty_packets=1.
- bytes_last_word=0 on a 1-word packet → data_valid=8'hFF, data unshifted, last=1.
- Reset asserted while in HOLD → next cycle all outputs are 0. After release, grant restarts at engine 0 and no stale packet_read pulse occurs.

Source files
------------

// File: rtl/nts_tx_pkg.sv
// Shared types and helpers for the NTS TX collector: FSM state encoding and
// the arithmetic that turns a left-aligned partial word into a right-aligned one.
package nts_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_GUARD   = 3'd5
  } tx_state_t;

  // A count of 0 (or anything above the word size) means the whole word is valid.
  function automatic int unsigned nts_norm_bytes(input int unsigned blw,
                                                 input int unsigned word_bytes);
    int unsigned n;
    if ((blw == 32'd0) || (blw > word_bytes)) begin
      n = word_bytes;
    end else begin
      n = blw;
    end
    return n;
  endfunction

  function automatic int unsigned nts_align_shift(input int unsigned n_bytes,
                                                  input int unsigned word_bytes);
    return 32'd8 * (word_bytes - n_bytes);
  endfunction

endpackage

// File: rtl/nts_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after i_last_grant,
// wrapping around, with i_last_grant itself checked last.
module nts_rr_arbiter #(
  parameter  int ENGINES = 4,
  localparam int IDX_W   = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
  input  logic [ENGINES-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_hit
);

  // Scan the ENGINES positions following the last grant and keep the first hit.
  always_comb begin
    int idx;
    o_grant = '0;
    o_hit   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= ENGINES; k++) begin
      idx = (int'(i_last_grant) + k) % ENGINES;
      if (!o_hit && i_req[idx]) begin
        o_hit   = 1'b1;
        o_grant = IDX_W'(idx);
      end else begin
        o_hit   = o_hit;
      end
    end
  end

endmodule

// File: rtl/nts_tx_arbiter.sv
// Multi-engine TX collector: round-robin picks an engine with a finished packet,
// drains its FIFO and streams it to the MAC with a right-aligned last-word byte mask.
module nts_tx_arbiter
  import nts_tx_pkg::*;
#(
  parameter int ENGINES        = 4,
  parameter int MAC_DATA_WIDTH = 64,
  parameter int BLW_WIDTH      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_areset,
  input  logic [ENGINES-1:0]            i_engine_tx_packet_available,
  output logic [ENGINES-1:0]            o_engine_tx_packet_read,
  input  logic [ENGINES-1:0]            i_engine_tx_fifo_empty,
  output logic [ENGINES-1:0]            o_engine_tx_fifo_rd_en,
  input  logic [MAC_DATA_WIDTH*ENGINES-1:0] i_engine_tx_fifo_rd_data,
  input  logic [BLW_WIDTH*ENGINES-1:0]  i_engine_tx_bytes_last_word,
  output logic                          o_mac_tx_valid,
  input  logic                          i_mac_tx_ready,
  output logic [MAC_DATA_WIDTH-1:0]     o_mac_tx_data,
  output logic [MAC_DATA_WIDTH/8-1:0]   o_mac_tx_data_valid,
  output logic                          o_mac_tx_last,
  output logic                          o_busy,
  output logic [31:0]                   o_packets_sent,
  output logic [31:0]                   o_empty_packets
);

  localparam int BYTES = MAC_DATA_WIDTH / 8;
  localparam int IDX_W = (ENGINES > 1) ? $clog2(ENGINES) : 1;
  localparam logic [ENGINES-1:0] ONE_HOT0 = ENGINES'(1'b1);

  tx_state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_grant, r_last_grant, w_arb_grant;
  logic                     w_arb_hit;
  logic [MAC_DATA_WIDTH-1:0] r_hold;
  logic [31:0]              r_packets_sent, r_empty_packets;

  logic                     w_empty_g;
  logic [MAC_DATA_WIDTH-1:0] w_rd_data_g;
  logic [BLW_WIDTH-1:0]     w_blw_g;
  logic [ENGINES-1:0]       w_sel;
  int unsigned              w_n, w_shift;

  logic w_capture, w_inc_sent, w_inc_empty, w_load_grant;
  logic w_rd_pulse, w_read_pulse, w_valid, w_last;

  nts_rr_arbiter #(.ENGINES(ENGINES)) u_rr (
    .i_req        (i_engine_tx_packet_available),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_hit        (w_arb_hit)
  );

  assign w_empty_g   = i_engine_tx_fifo_empty[r_grant];
  assign w_rd_data_g = i_engine_tx_fifo_rd_data[r_grant*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
  assign w_blw_g     = i_engine_tx_bytes_last_word[r_grant*BLW_WIDTH +: BLW_WIDTH];
  assign w_sel       = ONE_HOT0 << r_grant;
  assign w_n         = nts_norm_bytes(32'(w_blw_g), BYTES);
  assign w_shift     = nts_align_shift(w_n, BYTES);

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_inc_sent   = 1'b0;
    w_inc_empty  = 1'b0;
    w_load_grant = 1'b0;
    w_rd_pulse   = 1'b0;
    w_read_pulse = 1'b0;
    w_valid      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_hit) begin
          w_load_grant = 1'b1;
          w_state_nxt  = ST_FETCH;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (w_empty_g) begin
          w_inc_empty = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_rd_pulse  = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_valid = 1'b1;
        // FIFO drained after the word now on the bus means this is the last one.
        w_last  = w_empty_g;
        if (i_mac_tx_ready) begin
          if (w_empty_g) begin
            w_inc_sent  = 1'b1;
            w_state_nxt = ST_RELEASE;
          end else begin
            w_rd_pulse  = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_RELEASE: begin
        w_read_pulse = 1'b1;
        w_state_nxt  = ST_GUARD;
      end
      ST_GUARD: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping, word hold register and counters.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_state         <= ST_IDLE;
      r_grant         <= '0;
      r_last_grant    <= IDX_W'(ENGINES - 1);
      r_hold          <= '0;
      r_packets_sent  <= 32'd0;
      r_empty_packets <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_grant) begin
        r_grant <= w_arb_grant;
      end else begin
        r_grant <= r_grant;
      end
      if (r_state == ST_RELEASE) begin
        r_last_grant <= r_grant;
      end else begin
        r_last_grant <= r_last_grant;
      end
      if (w_capture) begin
        r_hold <= w_rd_data_g;
      end else begin
        r_hold <= r_hold;
      end
      if (w_inc_sent) begin
        r_packets_sent <= r_packets_sent + 32'd1;
      end else begin
        r_packets_sent <= r_packets_sent;
      end
      if (w_inc_empty) begin
        r_empty_packets <= r_empty_packets + 32'd1;
      end else begin
        r_empty_packets <= r_empty_packets;
      end
    end
  end

  // MAC stream: the last word is shifted down so its valid bytes sit at the LSBs.
  always_comb begin
    o_mac_tx_valid      = w_valid;
    o_mac_tx_last       = w_last;
    o_mac_tx_data       = '0;
    o_mac_tx_data_valid = '0;
    if (w_valid && w_last) begin
      o_mac_tx_data       = r_hold >> w_shift;
      o_mac_tx_data_valid = ~({BYTES{1'b1}} << w_n);
    end else if (w_valid) begin
      o_mac_tx_data       = r_hold;
      o_mac_tx_data_valid = {BYTES{1'b1}};
    end else begin
      o_mac_tx_data       = '0;
      o_mac_tx_data_valid = '0;
    end
  end

  assign o_engine_tx_fifo_rd_en  = w_rd_pulse   ? w_sel : '0;
  assign o_engine_tx_packet_read = w_read_pulse ? w_sel : '0;
  assign o_busy                  = (r_state != ST_IDLE);
  assign o_packets_sent          = r_packets_sent;
  assign o_empty_packets         = r_empty_packets;

endmodule
